alu_writeback_stage: RTL and testbench

//   Registered stage directly downstream of the combinational alu. Captures resultAccumulator and flags
//   on a valid/ready handshake and holds the architectural accumulator, which feeds back as alu operandA.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_writeback_stage_sync_fifo.sv | 59 +++++
 rtl/alu_writeback_stage.sv | 91 +++++++++
 tb/tb_alu_writeback_stage.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Definitions shared by the alu, the decoder and the alu writeback stage.
package alu_pkg;

    // Bit positions inside the 4-bit {Z,N,C,V} flag vector
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    localparam int unsigned FLAG_W = 4;

    typedef enum logic [4:0] {
        ALU_OP_ADD = 5'b00000,
        ALU_OP_SUB = 5'b00001,
        ALU_OP_AND = 5'b00010,
        ALU_OP_OR  = 5'b00011,
        ALU_OP_XOR = 5'b00100,
        ALU_OP_LSL = 5'b00101,
        ALU_OP_RSL = 5'b00110,
        ALU_OP_ASR = 5'b00111,
        ALU_OP_PASS = 5'b01000
    } alu_op_e;

endpackage

// File: rtl/alu_writeback_stage_sync_fifo.sv
// Small synchronous FIFO with registered storage; head entry is read directly from storage.
module sync_fifo #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    cnt_q;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    // A full FIFO can still take a push when the head leaves in the same cycle
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                cnt_q <= cnt_q + CW'(1);
            end else if (!push_ok && pop_ok) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = cnt_q;

endmodule

// File: rtl/alu_writeback_stage.sv
// Registered stage after the alu: accumulator and flag registers plus a
// writeback FIFO toward the register file.
module alu_writeback_stage
    import alu_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned RW    = 4,
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_result,
    input  logic [FLAG_W-1:0] in_flags,
    input  logic              acc_we,
    input  logic              flags_we,
    input  logic              wb_en,
    input  logic [RW-1:0]     wb_dest_in,
    input  logic              acc_clr,
    output logic [W-1:0]      acc,
    output logic [FLAG_W-1:0] flags_q,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [W-1:0]      wb_data,
    output logic [RW-1:0]     wb_dest,
    output logic [CW-1:0]     fifo_cnt
);

    logic [W-1:0]      acc_q;
    logic [W-1:0]      acc_d;
    logic [FLAG_W-1:0] flags_d;
    logic              xfer_c;
    logic              push_c;
    logic              pop_c;
    logic              fifo_full;
    logic              fifo_empty;
    logic [RW+W-1:0]   head_entry;

    // Every transfer needs FIFO room, even without a writeback, so results stay in order
    assign pop_c    = wb_valid & wb_ready;
    assign in_ready = ~rst & (~fifo_full | pop_c);
    assign xfer_c   = in_valid & in_ready;
    assign push_c   = xfer_c & wb_en;

    // Clear wins over a same-cycle accumulator load
    always_comb begin
        acc_d   = acc_q;
        flags_d = flags_q;
        if (acc_clr) begin
            acc_d = '0;
        end else if (xfer_c && acc_we) begin
            acc_d = in_result;
        end
        if (xfer_c && flags_we) begin
            flags_d = in_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            flags_q <= '0;
        end else begin
            acc_q   <= acc_d;
            flags_q <= flags_d;
        end
    end

    sync_fifo #(
        .WIDTH (RW + W),
        .DEPTH (DEPTH)
    ) u_wb_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_c),
        .push_data ({wb_dest_in, in_result}),
        .pop       (pop_c),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

    assign acc      = acc_q;
    assign wb_valid = ~fifo_empty;
    assign wb_dest  = head_entry[RW+W-1:W];
    assign wb_data  = head_entry[W-1:0];

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Randomized and directed bench for alu_writeback_stage against a queue-based reference model.
module tb_alu_writeback_stage;
    import alu_pkg::*;

    localparam int unsigned W     = 16;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned RW    = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_result;
    logic [3:0]    in_flags;
    logic          acc_we;
    logic          flags_we;
    logic          wb_en;
    logic [RW-1:0] wb_dest_in;
    logic          acc_clr;
    logic [W-1:0]  acc;
    logic [3:0]    flags_q;
    logic          wb_valid;
    logic          wb_ready;
    logic [W-1:0]  wb_data;
    logic [RW-1:0] wb_dest;
    logic [CW-1:0] fifo_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [W-1:0]    m_acc;
    logic [3:0]      m_flags;
    logic [RW+W-1:0] m_q[$];

    alu_writeback_stage #(.W(W), .DEPTH(DEPTH), .RW(RW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_flags   (in_flags),
        .acc_we     (acc_we),
        .flags_we   (flags_we),
        .wb_en      (wb_en),
        .wb_dest_in (wb_dest_in),
        .acc_clr    (acc_clr),
        .acc        (acc),
        .flags_q    (flags_q),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_data    (wb_data),
        .wb_dest    (wb_dest),
        .fifo_cnt   (fifo_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Compare all registered outputs against the model (called at a falling edge)
    task automatic check_state();
        check("acc", 32'(acc), 32'(m_acc));
        check("flags", 32'(flags_q), 32'(m_flags));
        check("fifo_cnt", 32'(fifo_cnt), 32'(m_q.size()));
        check("wb_valid", 32'(wb_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            check("wb_data", 32'(wb_data), 32'(m_q[0][W-1:0]));
            check("wb_dest", 32'(wb_dest), 32'(m_q[0][RW+W-1:W]));
        end
    endtask

    // Apply one cycle of inputs (from a falling edge), check in_ready, advance model and DUT
    task automatic drive(input logic r, input logic v, input logic [W-1:0] res,
                         input logic [3:0] fl, input logic awe, input logic fwe,
                         input logic wbe, input logic [RW-1:0] dst,
                         input logic clr, input logic rdy);
        logic exp_ready;
        logic xfer;
        rst = r; in_valid = v; in_result = res; in_flags = fl;
        acc_we = awe; flags_we = fwe; wb_en = wbe; wb_dest_in = dst;
        acc_clr = clr; wb_ready = rdy;
        #1;
        exp_ready = !r && ((m_q.size() < DEPTH) || (m_q.size() > 0 && rdy));
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        if (r) begin
            m_acc   = '0;
            m_flags = '0;
            m_q.delete();
        end else begin
            xfer = v && exp_ready;
            if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
            if (clr) m_acc = '0;
            else if (xfer && awe) m_acc = res;
            if (xfer && fwe) m_flags = fl;
            if (xfer && wbe) m_q.push_back({dst, res});
        end
        @(posedge clk);
        @(negedge clk);
        check_state();
    endtask

    initial begin
        logic [W-1:0] third;
        rst = 1'b1; in_valid = 1'b0; in_result = '0; in_flags = '0;
        acc_we = 1'b0; flags_we = 1'b0; wb_en = 1'b0; wb_dest_in = '0;
        acc_clr = 1'b0; wb_ready = 1'b0;
        m_acc = '0; m_flags = '0;
        @(negedge clk);

        // T1: reset held two cycles with a valid input offered
        drive(1, 1, 16'h1234, 4'hF, 1, 1, 1, 4'd5, 0, 0);
        drive(1, 1, 16'h1234, 4'hF, 1, 1, 1, 4'd5, 0, 0);
        check("t1_acc", 32'(acc), 32'd0);
        check("t1_flags", 32'(flags_q), 32'd0);
        check("t1_wb_valid", 32'(wb_valid), 32'd0);
        check("t1_wb_data", 32'(wb_data), 32'd0);
        check("t1_wb_dest", 32'(wb_dest), 32'd0);

        // T2: capture into acc and FIFO
        drive(0, 1, 16'd1024, 4'b0000, 1, 1, 1, 4'd3, 0, 0);
        check("t2_acc", 32'(acc), 32'd1024);
        check("t2_wb_valid", 32'(wb_valid), 32'd1);
        check("t2_wb_data", 32'(wb_data), 32'd1024);
        check("t2_wb_dest", 32'(wb_dest), 32'd3);

        // T3: signed result kept bit-exact, N flag captured; pending entry drains
        drive(0, 1, 16'hFF98, 4'b0100, 1, 1, 0, 4'd0, 0, 1);
        check("t3_acc", 32'(acc), 32'h0000FF98);
        check("t3_flag_n", 32'(flags_q[FLAG_N]), 32'd1);
        check("t3_cnt", 32'(fifo_cnt), 32'd0);

        // T4: back-pressure and simultaneous push/pop when full
        third = 16'd77;
        drive(0, 1, 16'd18, 4'b0000, 0, 0, 1, 4'd1, 0, 0);
        drive(0, 1, 16'd5,  4'b0000, 0, 0, 1, 4'd2, 0, 0);
        check("t4_cnt_full", 32'(fifo_cnt), 32'd2);
        drive(0, 1, third, 4'b0000, 0, 0, 1, 4'd4, 0, 0);
        check("t4_held_cnt", 32'(fifo_cnt), 32'd2);
        check("t4_head18", 32'(wb_data), 32'd18);
        drive(0, 1, third, 4'b0000, 0, 0, 1, 4'd4, 0, 1);
        check("t4_cnt_same", 32'(fifo_cnt), 32'd2);
        check("t4_head5", 32'(wb_data), 32'd5);
        drive(0, 0, 16'd0, 4'b0000, 0, 0, 0, 4'd0, 0, 1);
        check("t4_head_third", 32'(wb_data), 32'(third));
        check("t4_dest_third", 32'(wb_dest), 32'd4);
        drive(0, 0, 16'd0, 4'b0000, 0, 0, 0, 4'd0, 0, 1);
        check("t4_empty", 32'(wb_valid), 32'd0);

        // T5: clear beats write, flags still load
        drive(0, 1, 16'd7, 4'b0001, 1, 1, 0, 4'd0, 1, 1);
        check("t5_acc", 32'(acc), 32'd0);
        check("t5_flags", 32'(flags_q), 32'b0001);

        // T6: reset discards queued writebacks, then normal push
        drive(0, 1, 16'd11, 4'b0000, 1, 0, 1, 4'd6, 0, 0);
        drive(0, 1, 16'd12, 4'b0000, 1, 0, 1, 4'd7, 0, 0);
        check("t6_cnt2", 32'(fifo_cnt), 32'd2);
        drive(1, 0, 16'd0, 4'b0000, 0, 0, 0, 4'd0, 0, 0);
        check("t6_cnt0", 32'(fifo_cnt), 32'd0);
        check("t6_wb_valid", 32'(wb_valid), 32'd0);
        check("t6_acc", 32'(acc), 32'd0);
        drive(0, 1, 16'd42, 4'b0000, 0, 0, 1, 4'd9, 0, 0);
        check("t6_after_valid", 32'(wb_valid), 32'd1);
        check("t6_after_data", 32'(wb_data), 32'd42);
        check("t6_after_dest", 32'(wb_dest), 32'd9);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 49) == 0),
                  1'($urandom),
                  16'($urandom),
                  4'($urandom),
                  1'($urandom),
                  1'($urandom),
                  ($urandom_range(0, 3) != 0),
                  4'($urandom),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 2) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
